// File: rtl/bt_uart_rx.sv
// bt_uart_rx: 16x oversampled UART receiver with majority voting, framing check and output FIFO.
// Define BT_RX_PARITY_EN to build the parity bit state and parity_err checking.
module bt_uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] led,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW  = $clog2(DATA_BITS);

`ifdef BT_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            s_q, s_d;
    logic [NW-1:0]         n_q, n_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  smp7_q, smp7_d, smp8_q, smp8_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_BITS-1:0]  led_q, led_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
`ifdef BT_RX_PARITY_EN
    logic                  par_q, par_d;
    logic                  parity_err_q, parity_err_d;
    logic                  parity_bad;
`endif

    logic tick, at_s9, at_s15, bit_maj, decide, good;
    logic empty, full, pop, push;

    assign tick    = (cnt_q == CW'(DIV - 1));
    assign at_s9   = tick && (s_q == 4'd9);
    assign at_s15  = tick && (s_q == 4'd15);
    // Samples at s=7 and s=8 are held; the s=9 sample is the live synchronised input.
    assign bit_maj = (smp7_q & smp8_q) | (smp7_q & rx_s_q) | (smp8_q & rx_s_q);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        s_d     = tick ? s_q + 4'd1 : s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        smp7_d  = (tick && s_q == 4'd7) ? rx_s_q : smp7_q;
        smp8_d  = (tick && s_q == 4'd8) ? rx_s_q : smp8_q;
        decide  = 1'b0;
`ifdef BT_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    s_d     = '0;
                end
            end
            S_START: begin
                if (at_s9 && bit_maj) begin
                    state_d = S_IDLE;
                end else if (at_s15) begin
                    state_d = S_DATA;
                    n_d     = '0;
                end
            end
            S_DATA: begin
                if (at_s9) shreg_d[n_q] = bit_maj;
                if (at_s15) begin
                    if (n_q == NW'(DATA_BITS - 1)) begin
`ifdef BT_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
`ifdef BT_RX_PARITY_EN
            S_PARITY: begin
                if (at_s9)  par_d   = bit_maj;
                if (at_s15) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so a following start edge is never missed.
                if (at_s9) begin
                    decide  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[AW] != wr_ptr_q[AW]) &&
                   (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    assign pop   = !empty && ready;

`ifdef BT_RX_PARITY_EN
    assign parity_bad   = ((^{shreg_q, par_q}) != PARITY_ODD);
    assign good         = decide && bit_maj && !parity_bad;
    assign parity_err_d = decide && bit_maj && parity_bad;
`else
    assign good = decide && bit_maj;
`endif
    assign push        = good && (!full || pop);
    assign frame_err_d = decide && !bit_maj;
    assign overrun_d   = good && full && !pop;
    assign led_d       = push ? shreg_q : led_q;
    assign rd_ptr_d    = rd_ptr_q + (AW + 1)'(pop);
    assign wr_ptr_d    = wr_ptr_q + (AW + 1)'(push);

    // The head after this edge may be the byte being written right now.
    always_comb begin
        data_d = mem[rd_ptr_d[AW-1:0]];
        if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) data_d = shreg_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            s_q          <= '0;
            n_q          <= '0;
            shreg_q      <= '0;
            smp7_q       <= 1'b1;
            smp8_q       <= 1'b1;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            led_q        <= '0;
            data_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
`ifdef BT_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s_q          <= s_d;
            n_q          <= n_d;
            shreg_q      <= shreg_d;
            smp7_q       <= smp7_d;
            smp8_q       <= smp8_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            led_q        <= led_d;
            data_q       <= data_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
`ifdef BT_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= shreg_q;
    end

    assign data      = data_q;
    assign valid     = !empty;
    assign led       = led_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef BT_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bt_uart_rx.sv
// Directed testbench for bt_uart_rx at DIV=10 (160 clocks per bit).
// Parity scenarios are included when BT_RX_PARITY_EN is defined.
module tb_bt_uart_rx;

    localparam int BIT_CLKS = 160;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       rx       = 1'b1;
    logic       ready    = 1'b0;
    logic [7:0] data, led;
    logic       valid, frame_err, parity_err, overrun;

    int n_vec  = 0;
    int n_miss = 0;

    // Event counters and pop log, written only by the monitor below.
    int         cyc = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, valid_cnt = 0, pop_n = 0;
    logic [7:0] pop_val [64];
    int         pop_cyc [64];
    logic [7:0] exp_led = 8'h00;

    bt_uart_rx #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (10_000),
        .DATA_BITS (8),
        .FIFO_DEPTH(4),
        .PARITY_ODD(1'b0)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .led       (led),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        cyc = cyc + 1;
        if (frame_err)  fe_cnt = fe_cnt + 1;
        if (parity_err) pe_cnt = pe_cnt + 1;
        if (overrun)    ov_cnt = ov_cnt + 1;
        if (valid)      valid_cnt = valid_cnt + 1;
        if (valid && ready && pop_n < 64) begin
            pop_val[pop_n] = data;
            pop_cyc[pop_n] = cyc;
            pop_n = pop_n + 1;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input logic with_par, input logic par_v);
        rx = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clks(BIT_CLKS);
        end
        if (with_par) begin
            rx = par_v;
            clks(BIT_CLKS);
        end
        rx = stop_v;
        clks(BIT_CLKS);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clks(5);
        @(negedge CLOCK_50);
        n_vec++; if (valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid got %b want 0", valid); end
        n_vec++; if (data !== 8'h00) begin n_miss++; $display("FAIL reset_data got %h want 00", data); end
        n_vec++; if (led !== 8'h00) begin n_miss++; $display("FAIL reset_led got %h want 00", led); end
        n_vec++; if (frame_err !== 1'b0) begin n_miss++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_vec++; if (parity_err !== 1'b0) begin n_miss++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
        n_vec++; if (overrun !== 1'b0) begin n_miss++; $display("FAIL reset_overrun got %b want 0", overrun); end
        clks(1);
        reset = 1'b0;
        clks(20);
    endtask

    task automatic test_single;
        int p0, v0, f0, o0;
        p0 = pop_n; v0 = valid_cnt; f0 = fe_cnt; o0 = ov_cnt;
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        clks(20);
        exp_led = 8'hA5;
        n_vec++; if (pop_n - p0 !== 1) begin n_miss++; $display("FAIL single_pops got %0d want 1", pop_n - p0); end
        n_vec++; if (pop_val[p0] !== 8'hA5) begin n_miss++; $display("FAIL single_data got %h want a5", pop_val[p0]); end
        n_vec++; if (valid_cnt - v0 !== 1) begin n_miss++; $display("FAIL single_valid_cycles got %0d want 1", valid_cnt - v0); end
        n_vec++; if (led !== exp_led) begin n_miss++; $display("FAIL single_led got %h want %h", led, exp_led); end
        n_vec++; if (fe_cnt - f0 + ov_cnt - o0 !== 0) begin n_miss++; $display("FAIL single_errors got %0d want 0", fe_cnt - f0 + ov_cnt - o0); end
    endtask

    task automatic test_false_start;
        int p0, v0, f0;
        p0 = pop_n; v0 = valid_cnt; f0 = fe_cnt;
        rx = 1'b0;
        clks(60);
        rx = 1'b1;
        clks(300);
        n_vec++; if (valid_cnt - v0 !== 0) begin n_miss++; $display("FAIL false_start_valid got %0d want 0", valid_cnt - v0); end
        n_vec++; if (fe_cnt - f0 !== 0) begin n_miss++; $display("FAIL false_start_frame_err got %0d want 0", fe_cnt - f0); end
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        clks(20);
        exp_led = 8'h3C;
        n_vec++; if (pop_n - p0 !== 1) begin n_miss++; $display("FAIL after_false_pops got %0d want 1", pop_n - p0); end
        n_vec++; if (pop_val[p0] !== 8'h3C) begin n_miss++; $display("FAIL after_false_data got %h want 3c", pop_val[p0]); end
        n_vec++; if (led !== exp_led) begin n_miss++; $display("FAIL after_false_led got %h want %h", led, exp_led); end
    endtask

    task automatic test_back_to_back_overrun;
        int p0, o0;
        logic [7:0] b;
        o0 = ov_cnt;
        ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            b = 8'(v);
            send_frame(b, 1'b1, 1'b0, 1'b0);
        end
        clks(20);
        exp_led = 8'h04;
        n_vec++; if (ov_cnt - o0 !== 1) begin n_miss++; $display("FAIL overrun_pulses got %0d want 1", ov_cnt - o0); end
        n_vec++; if (led !== exp_led) begin n_miss++; $display("FAIL overrun_led got %h want %h", led, exp_led); end
        n_vec++; if (valid !== 1'b1) begin n_miss++; $display("FAIL full_valid got %b want 1", valid); end
        n_vec++; if (data !== 8'h01) begin n_miss++; $display("FAIL full_head got %h want 01", data); end
        p0 = pop_n;
        ready = 1'b1;
        clks(8);
        n_vec++; if (pop_n - p0 !== 4) begin n_miss++; $display("FAIL drain_pops got %0d want 4", pop_n - p0); end
        for (int k = 0; k < 4; k++) begin
            b = 8'(k + 1);
            n_vec++; if (pop_val[p0+k] !== b) begin n_miss++; $display("FAIL drain_data%0d got %h want %h", k, pop_val[p0+k], b); end
            if (k > 0) begin
                n_vec++; if (pop_cyc[p0+k] - pop_cyc[p0] !== k) begin n_miss++; $display("FAIL drain_cycle%0d got %0d want %0d", k, pop_cyc[p0+k] - pop_cyc[p0], k); end
            end
        end
        n_vec++; if (valid !== 1'b0) begin n_miss++; $display("FAIL drained_valid got %b want 0", valid); end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        v0 = valid_cnt; f0 = fe_cnt;
        ready = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        clks(300);
        n_vec++; if (fe_cnt - f0 !== 1) begin n_miss++; $display("FAIL frame_err_pulses got %0d want 1", fe_cnt - f0); end
        n_vec++; if (valid_cnt - v0 !== 0) begin n_miss++; $display("FAIL frame_err_valid got %0d want 0", valid_cnt - v0); end
        n_vec++; if (led !== exp_led) begin n_miss++; $display("FAIL frame_err_led got %h want %h", led, exp_led); end
    endtask

`ifdef BT_RX_PARITY_EN
    task automatic test_parity;
        int p0, e0;
        p0 = pop_n; e0 = pe_cnt;
        ready = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        clks(20);
        exp_led = 8'h07;
        n_vec++; if (pop_n - p0 !== 1) begin n_miss++; $display("FAIL parity_good_pops got %0d want 1", pop_n - p0); end
        n_vec++; if (pop_val[p0] !== 8'h07) begin n_miss++; $display("FAIL parity_good_data got %h want 07", pop_val[p0]); end
        n_vec++; if (pe_cnt - e0 !== 0) begin n_miss++; $display("FAIL parity_good_err got %0d want 0", pe_cnt - e0); end
        p0 = pop_n;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        clks(20);
        n_vec++; if (pe_cnt - e0 !== 1) begin n_miss++; $display("FAIL parity_bad_err got %0d want 1", pe_cnt - e0); end
        n_vec++; if (pop_n - p0 !== 0) begin n_miss++; $display("FAIL parity_bad_pops got %0d want 0", pop_n - p0); end
        n_vec++; if (led !== exp_led) begin n_miss++; $display("FAIL parity_bad_led got %h want %h", led, exp_led); end
    endtask
`else
    task automatic test_parity;
        n_vec++; if (pe_cnt !== 0) begin n_miss++; $display("FAIL parity_err_tied got %0d pulses want 0", pe_cnt); end
    endtask
`endif

    task automatic test_reset_mid_frame;
        int p0, f0, o0;
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        rx = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h22 >> i) & 8'h01;
            clks(BIT_CLKS);
        end
        @(negedge CLOCK_50);
        n_vec++; if (valid !== 1'b1) begin n_miss++; $display("FAIL queued_valid got %b want 1", valid); end
        clks(1);
        reset = 1'b1;
        clks(1);
        reset = 1'b0;
        rx = 1'b1;
        @(negedge CLOCK_50);
        exp_led = 8'h00;
        n_vec++; if (valid !== 1'b0) begin n_miss++; $display("FAIL midreset_valid got %b want 0", valid); end
        n_vec++; if (data !== 8'h00) begin n_miss++; $display("FAIL midreset_data got %h want 00", data); end
        n_vec++; if (led !== exp_led) begin n_miss++; $display("FAIL midreset_led got %h want %h", led, exp_led); end
        f0 = fe_cnt; o0 = ov_cnt;
        clks(400);
        n_vec++; if (valid !== 1'b0) begin n_miss++; $display("FAIL midreset_idle_valid got %b want 0", valid); end
        n_vec++; if (fe_cnt - f0 + ov_cnt - o0 !== 0) begin n_miss++; $display("FAIL midreset_errors got %0d want 0", fe_cnt - f0 + ov_cnt - o0); end
        p0 = pop_n;
        ready = 1'b1;
        send_frame(8'h9E, 1'b1, 1'b0, 1'b0);
        clks(20);
        exp_led = 8'h9E;
        n_vec++; if (pop_n - p0 !== 1) begin n_miss++; $display("FAIL post_reset_pops got %0d want 1", pop_n - p0); end
        n_vec++; if (pop_val[p0] !== 8'h9E) begin n_miss++; $display("FAIL post_reset_data got %h want 9e", pop_val[p0]); end
        n_vec++; if (led !== exp_led) begin n_miss++; $display("FAIL post_reset_led got %h want %h", led, exp_led); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_false_start();
        test_back_to_back_overrun();
        test_frame_err();
        test_parity();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
